gb_apu_sweep: RTL and testbench

- Channel 1 frequency sweep unit. Sits directly downstream of the frame sequencer and consumes its `sweep_clk` tick, which runs at 128 Hz as a 1-cycle strobe.
- Holds the shadow frequency and periodically recomputes the channel-1 period from the NR10 fields.
- Writes the new frequency back to the channel-1 frequency register (NR13/NR14 path).
- Signals overflow so the channel-1 controller can disable the channel.

---
 rtl/gb_apu_sweep.sv | 142 ++++++++++++++
 tb/tb_gb_apu_sweep.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gb_apu_sweep.sv
// Channel 1 frequency sweep unit: shadow frequency, sweep timer and
// write-back / overflow FSM driven by the frame sequencer's sweep tick.
module gb_apu_sweep #(
  parameter int unsigned FREQ_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sweep_clk,
  input  logic              trigger,
  input  logic [2:0]        sweep_period,
  input  logic              sweep_negate,
  input  logic [2:0]        sweep_shift,
  input  logic [FREQ_W-1:0] freq_in,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_wr,
  output logic              sweep_en,
  output logic              ch_disable
);

  localparam int unsigned TIMER_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [FREQ_W-1:0]   shadow, shadow_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                neg_used, neg_used_n;
  logic                sweep_en_n;
  logic [FREQ_W-1:0]   freq_out_n;
  logic                freq_wr_n;
  logic                ch_disable_n;

  logic [TIMER_W-1:0]  reload_c;
  logic [FREQ_W-1:0]   delta_c;
  logic [FREQ_W:0]     sum_c;
  logic [FREQ_W-1:0]   calc_c;
  logic                overflow_c;
  logic                fire_req_c;

  // Sweep arithmetic on the registered shadow; subtraction can never wrap
  assign reload_c   = (sweep_period == 3'd0) ? TIMER_W'(8) : TIMER_W'(sweep_period);
  assign delta_c    = shadow >> sweep_shift;
  assign sum_c      = {1'b0, shadow} + {1'b0, delta_c};
  assign overflow_c = !sweep_negate && sum_c[FREQ_W];
  assign calc_c     = sweep_negate ? (shadow - delta_c) : sum_c[FREQ_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '0;
      timer      <= '0;
      neg_used   <= 1'b0;
      sweep_en   <= 1'b0;
      freq_out   <= '0;
      freq_wr    <= 1'b0;
      ch_disable <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      timer      <= timer_n;
      neg_used   <= neg_used_n;
      sweep_en   <= sweep_en_n;
      freq_out   <= freq_out_n;
      freq_wr    <= freq_wr_n;
      ch_disable <= ch_disable_n;
    end
  end

  always_comb begin
    state_n      = state;
    shadow_n     = shadow;
    timer_n      = timer;
    neg_used_n   = neg_used;
    sweep_en_n   = sweep_en;
    freq_out_n   = freq_out;
    freq_wr_n    = 1'b0;
    ch_disable_n = 1'b0;
    fire_req_c   = 1'b0;

    if (trigger) begin
      shadow_n   = freq_in;
      timer_n    = reload_c;
      neg_used_n = 1'b0;
      sweep_en_n = (sweep_period != 3'd0) || (sweep_shift != 3'd0);
      state_n    = (sweep_shift != 3'd0) ? CHECK : IDLE;
    end else begin
      if (sweep_clk) begin
        if (timer <= TIMER_W'(1)) begin
          timer_n    = reload_c;
          fire_req_c = sweep_en && (sweep_period != 3'd0);
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end

      case (state)
        FIRE: begin
          if (sweep_negate) neg_used_n = 1'b1;
          if (overflow_c) begin
            ch_disable_n = 1'b1;
            sweep_en_n   = 1'b0;
            state_n      = IDLE;
          end else if (sweep_shift != 3'd0) begin
            shadow_n   = calc_c;
            freq_out_n = calc_c;
            freq_wr_n  = 1'b1;
            state_n    = CHECK;
          end else begin
            state_n = IDLE;
          end
        end
        CHECK: begin
          if (sweep_negate) neg_used_n = 1'b1;
          if (overflow_c) begin
            ch_disable_n = 1'b1;
            sweep_en_n   = 1'b0;
          end
          state_n = IDLE;
        end
        default: begin
          if (fire_req_c) state_n = FIRE;
        end
      endcase

      // Leaving negate mode after it was used kills the channel; this wins over any write
      if (neg_used && !sweep_negate && sweep_en) begin
        ch_disable_n = 1'b1;
        sweep_en_n   = 1'b0;
        neg_used_n   = 1'b0;
        freq_wr_n    = 1'b0;
        shadow_n     = shadow;
        freq_out_n   = freq_out;
        state_n      = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_gb_apu_sweep.sv
// Directed testbench for gb_apu_sweep with hand-computed expectations.
module tb_gb_apu_sweep;

  localparam int unsigned FREQ_W = 11;

  logic              clk;
  logic              reset;
  logic              sweep_clk;
  logic              trigger;
  logic [2:0]        sweep_period;
  logic              sweep_negate;
  logic [2:0]        sweep_shift;
  logic [FREQ_W-1:0] freq_in;
  logic [FREQ_W-1:0] freq_out;
  logic              freq_wr;
  logic              sweep_en;
  logic              ch_disable;

  int passed = 0;
  int total  = 0;

  gb_apu_sweep #(.FREQ_W(FREQ_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sweep_clk    (sweep_clk),
    .trigger      (trigger),
    .sweep_period (sweep_period),
    .sweep_negate (sweep_negate),
    .sweep_shift  (sweep_shift),
    .freq_in      (freq_in),
    .freq_out     (freq_out),
    .freq_wr      (freq_wr),
    .sweep_en     (sweep_en),
    .ch_disable   (ch_disable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_trigger(input logic [FREQ_W-1:0] f, input logic [2:0] per,
                            input logic [2:0] sh, input logic neg);
    freq_in      = f;
    sweep_period = per;
    sweep_shift  = sh;
    sweep_negate = neg;
    trigger      = 1'b1;
    step();
    trigger      = 1'b0;
  endtask

  task automatic pulse_sweep();
    sweep_clk = 1'b1;
    step();
    sweep_clk = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (freq_out !== 11'h000) $display("FAIL reset_freq_out got=%h exp=000", freq_out); else passed++;
    total++; if (freq_wr !== 1'b0) $display("FAIL reset_freq_wr got=%b exp=0", freq_wr); else passed++;
    total++; if (sweep_en !== 1'b0) $display("FAIL reset_sweep_en got=%b exp=0", sweep_en); else passed++;
    total++; if (ch_disable !== 1'b0) $display("FAIL reset_ch_disable got=%b exp=0", ch_disable); else passed++;
  endtask

  task automatic test_add_overflow_check();
    do_trigger(11'h400, 3'd1, 3'd1, 1'b0);
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL add_trig_check got=%b exp=0", ch_disable); else passed++;
    total++; if (sweep_en !== 1'b1) $display("FAIL add_sweep_en got=%b exp=1", sweep_en); else passed++;
    pulse_sweep();
    total++; if (freq_wr !== 1'b0) $display("FAIL add_wr_early got=%b exp=0", freq_wr); else passed++;
    step();
    total++; if (freq_wr !== 1'b1) $display("FAIL add_wr got=%b exp=1", freq_wr); else passed++;
    total++; if (freq_out !== 11'h600) $display("FAIL add_freq_out got=%h exp=600", freq_out); else passed++;
    total++; if (ch_disable !== 1'b0) $display("FAIL add_dis_with_wr got=%b exp=0", ch_disable); else passed++;
    step();
    total++; if (ch_disable !== 1'b1) $display("FAIL add_check_dis got=%b exp=1", ch_disable); else passed++;
    total++; if (freq_wr !== 1'b0) $display("FAIL add_wr_single got=%b exp=0", freq_wr); else passed++;
    total++; if (sweep_en !== 1'b0) $display("FAIL add_sweep_off got=%b exp=0", sweep_en); else passed++;
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL add_dis_single got=%b exp=0", ch_disable); else passed++;
  endtask

  task automatic test_trigger_overflow();
    do_trigger(11'h7FF, 3'd1, 3'd1, 1'b0);
    total++; if (ch_disable !== 1'b0) $display("FAIL trig_ovf_early got=%b exp=0", ch_disable); else passed++;
    step();
    total++; if (ch_disable !== 1'b1) $display("FAIL trig_ovf_dis got=%b exp=1", ch_disable); else passed++;
    total++; if (freq_wr !== 1'b0) $display("FAIL trig_ovf_wr got=%b exp=0", freq_wr); else passed++;
    total++; if (sweep_en !== 1'b0) $display("FAIL trig_ovf_en got=%b exp=0", sweep_en); else passed++;
  endtask

  task automatic test_negate_quirk();
    do_trigger(11'h100, 3'd2, 3'd2, 1'b1);
    step();
    pulse_sweep();
    step();
    total++; if (freq_wr !== 1'b0) $display("FAIL neg_first_nowr got=%b exp=0", freq_wr); else passed++;
    pulse_sweep();
    step();
    total++; if (freq_wr !== 1'b1) $display("FAIL neg_wr got=%b exp=1", freq_wr); else passed++;
    total++; if (freq_out !== 11'h0C0) $display("FAIL neg_freq_out got=%h exp=0c0", freq_out); else passed++;
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL neg_check_nodis got=%b exp=0", ch_disable); else passed++;
    sweep_negate = 1'b0;
    step();
    total++; if (ch_disable !== 1'b1) $display("FAIL neg_quirk_dis got=%b exp=1", ch_disable); else passed++;
    total++; if (sweep_en !== 1'b0) $display("FAIL neg_quirk_en got=%b exp=0", sweep_en); else passed++;
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL neg_quirk_single got=%b exp=0", ch_disable); else passed++;
  endtask

  task automatic test_period0_shift0();
    int bad;
    bad = 0;
    do_trigger(11'h300, 3'd0, 3'd0, 1'b0);
    step();
    total++; if (sweep_en !== 1'b0) $display("FAIL p0s0_en got=%b exp=0", sweep_en); else passed++;
    for (int i = 0; i < 16; i++) begin
      pulse_sweep();
      if (freq_wr || ch_disable) bad++;
      step();
      if (freq_wr || ch_disable) bad++;
    end
    total++; if (bad !== 0) $display("FAIL p0s0_quiet got=%0d exp=0", bad); else passed++;
  endtask

  task automatic test_period0_shift3();
    int bad;
    bad = 0;
    do_trigger(11'h100, 3'd0, 3'd3, 1'b0);
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL p0s3_nodis got=%b exp=0", ch_disable); else passed++;
    total++; if (sweep_en !== 1'b1) $display("FAIL p0s3_en got=%b exp=1", sweep_en); else passed++;
    for (int i = 0; i < 20; i++) begin
      pulse_sweep();
      if (freq_wr || ch_disable) bad++;
      step();
      if (freq_wr || ch_disable) bad++;
    end
    total++; if (bad !== 0) $display("FAIL p0s3_nowr got=%0d exp=0", bad); else passed++;
    total++; if (sweep_en !== 1'b1) $display("FAIL p0s3_en_kept got=%b exp=1", sweep_en); else passed++;
  endtask

  task automatic test_collision();
    sweep_clk = 1'b1;
    do_trigger(11'h100, 3'd2, 3'd1, 1'b0);
    sweep_clk = 1'b0;
    step();
    total++; if (sweep_en !== 1'b1) $display("FAIL coll_en got=%b exp=1", sweep_en); else passed++;
    total++; if (ch_disable !== 1'b0) $display("FAIL coll_nodis got=%b exp=0", ch_disable); else passed++;
    pulse_sweep();
    step();
    total++; if (freq_wr !== 1'b0) $display("FAIL coll_timer_reload got=%b exp=0", freq_wr); else passed++;
    pulse_sweep();
    step();
    total++; if (freq_wr !== 1'b1) $display("FAIL coll_wr got=%b exp=1", freq_wr); else passed++;
    total++; if (freq_out !== 11'h180) $display("FAIL coll_freq_out got=%h exp=180", freq_out); else passed++;
    step();
    total++; if (ch_disable !== 1'b0) $display("FAIL coll_check got=%b exp=0", ch_disable); else passed++;
  endtask

  task automatic test_reset_in_fire();
    int bad;
    bad = 0;
    do_trigger(11'h100, 3'd1, 3'd1, 1'b0);
    step();
    pulse_sweep();
    #2;
    reset = 1'b1;
    #1;
    total++; if (freq_out !== 11'h000) $display("FAIL rst_fire_freq_out got=%h exp=000", freq_out); else passed++;
    total++; if (freq_wr !== 1'b0) $display("FAIL rst_fire_wr got=%b exp=0", freq_wr); else passed++;
    total++; if (sweep_en !== 1'b0) $display("FAIL rst_fire_en got=%b exp=0", sweep_en); else passed++;
    total++; if (ch_disable !== 1'b0) $display("FAIL rst_fire_dis got=%b exp=0", ch_disable); else passed++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (freq_wr || ch_disable || freq_out != 11'h000) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rst_fire_no_write got=%0d exp=0", bad); else passed++;
  endtask

  initial begin
    reset        = 1'b1;
    sweep_clk    = 1'b0;
    trigger      = 1'b0;
    sweep_period = 3'd0;
    sweep_negate = 1'b0;
    sweep_shift  = 3'd0;
    freq_in      = '0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_add_overflow_check();
    test_trigger_overflow();
    test_negate_quirk();
    test_period0_shift0();
    test_period0_shift3();
    test_collision();
    test_reset_in_fire();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
